image_frame_loader: RTL and testbench

Upstream feeder for `full_neural_network_v1`. Accepts a 256-pixel binary image as a byte stream (valid/ready) and assembles it into the network's 256-bit `layer_1_input` vector. Issues a single-cycle `load`, waits for the network's `done`, and presents the 4-bit `max` classification on a result handshake. Also guards against a stalled network with a timeout.

---
 rtl/nn_loader_pkg.sv | 11 +
 rtl/frame_shift_reg.sv | 42 ++++
 rtl/image_frame_loader.sv | 116 +++++++++++
 tb/tb_image_frame_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_loader_pkg.sv
// nn_loader_pkg: shared state type and default sizes for image_frame_loader.
//   Defaults: 256-bit image, 8-bit stream bytes, 4-bit digit.
//   TIMEOUT_DIGIT is the digit reported when the network never answers.
package nn_loader_pkg;
    localparam int IMAGE_BITS_DEF = 256;
    localparam int BYTE_W_DEF     = 8;
    localparam int DIGIT_W_DEF    = 4;
    localparam int IMAGE_BYTES    = IMAGE_BITS_DEF / BYTE_W_DEF;
    localparam logic [3:0] TIMEOUT_DIGIT = 4'hF;
    typedef enum logic [1:0] {FILL, LOAD, WAIT, RESULT} loader_state_t;
endpackage

// File: rtl/frame_shift_reg.sv
// frame_shift_reg: byte-wide shift register that assembles one image frame.
//   clk, reset   : clock and synchronous active-high reset
//   shift_en     : a byte is accepted this cycle
//   s_data       : byte to shift in at the LSB end
//   frame_next   : frame contents including the current byte
//   frame_full   : the current byte completes the frame
module frame_shift_reg
    import nn_loader_pkg::*;
#(
    parameter int NBYTES = IMAGE_BYTES,
    parameter int BYTE_W = BYTE_W_DEF
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     shift_en,
    input  logic [BYTE_W-1:0]        s_data,
    output logic [NBYTES*BYTE_W-1:0] frame_next,
    output logic                     frame_full
);
    localparam int BITS = NBYTES * BYTE_W;
    localparam int CW   = NBYTES > 1 ? $clog2(NBYTES) : 1;

    logic [BITS-1:0] frame_q, frame_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_comb begin
        frame_next = {frame_q[BITS-BYTE_W-1:0], s_data};
        frame_full = shift_en && cnt_q == CW'(NBYTES - 1);
        frame_d    = shift_en ? frame_next : frame_q;
        cnt_d      = frame_full ? '0 : cnt_q + CW'(shift_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q <= '0;
            cnt_q   <= '0;
        end else begin
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/image_frame_loader.sv
// image_frame_loader: streams a binary image in, launches the network, returns its digit.
//   s_data/s_valid/s_ready            : byte stream in, MSB = earliest pixel
//   layer_1_input, load               : frame vector and one-cycle start to the network
//   nn_done, nn_max                   : network completion and classification
//   result_digit/valid/ready, timeout_err : result handshake, 4'hF + err on timeout
//   busy                              : high outside FILL
module image_frame_loader
    import nn_loader_pkg::*;
#(
    parameter int IMAGE_BITS     = IMAGE_BITS_DEF,
    parameter int BYTE_W         = BYTE_W_DEF,
    parameter int DIGIT_W        = DIGIT_W_DEF,
    parameter int TIMEOUT_CYCLES = 4096
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BYTE_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [IMAGE_BITS-1:0] layer_1_input,
    output logic                  load,
    input  logic                  nn_done,
    input  logic [DIGIT_W-1:0]    nn_max,
    output logic [DIGIT_W-1:0]    result_digit,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  timeout_err,
    output logic                  busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    loader_state_t         state_q, state_d;
    logic [IMAGE_BITS-1:0] frame_next, layer_q, layer_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [DIGIT_W-1:0]    digit_q, digit_d, nn_max_q;
    logic                  err_q, err_d, nn_done_q, nn_done_prev_q;
    logic                  frame_full, rise, tmo_hit;

    frame_shift_reg #(
        .NBYTES(IMAGE_BITS / BYTE_W),
        .BYTE_W(BYTE_W)
    ) u_frame (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (s_valid && s_ready),
        .s_data    (s_data),
        .frame_next(frame_next),
        .frame_full(frame_full)
    );

    always_comb begin
        // Edge taken between two registered copies so a level left high from
        // the previous frame never counts, and nn_max_q lines up with it.
        rise    = nn_done_q && !nn_done_prev_q;
        tmo_hit = tmo_q == TW'(TIMEOUT_CYCLES - 1);
        state_d = state_q;
        layer_d = layer_q;
        tmo_d   = tmo_q;
        digit_d = digit_q;
        err_d   = err_q;
        case (state_q)
            FILL: if (frame_full) begin
                layer_d = frame_next;
                state_d = LOAD;
            end
            LOAD: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (rise) begin
                    digit_d = nn_max_q;
                    err_d   = 1'b0;
                    state_d = RESULT;
                end else if (tmo_hit) begin
                    digit_d = DIGIT_W'(TIMEOUT_DIGIT);
                    err_d   = 1'b1;
                    state_d = RESULT;
                end
            end
            RESULT: if (result_ready) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= FILL;
            layer_q        <= '0;
            tmo_q          <= '0;
            digit_q        <= '0;
            err_q          <= 1'b0;
            nn_done_q      <= 1'b0;
            nn_done_prev_q <= 1'b0;
            nn_max_q       <= '0;
        end else begin
            state_q        <= state_d;
            layer_q        <= layer_d;
            tmo_q          <= tmo_d;
            digit_q        <= digit_d;
            err_q          <= err_d;
            nn_done_q      <= nn_done;
            nn_done_prev_q <= nn_done_q;
            nn_max_q       <= nn_max;
        end
    end

    assign s_ready       = state_q == FILL;
    assign load          = state_q == LOAD;
    assign busy          = state_q != FILL;
    assign result_valid  = state_q == RESULT;
    assign layer_1_input = layer_q;
    assign result_digit  = digit_q;
    assign timeout_err   = err_q;
endmodule

// File: tb/tb_image_frame_loader.sv
// tb_image_frame_loader: randomized self-checking bench for image_frame_loader.
module tb_image_frame_loader;
    logic         clk = 0;
    logic         reset = 1;
    logic [7:0]   s_data = 0;
    logic         s_valid = 0;
    logic         s_ready;
    logic [255:0] layer_1_input;
    logic         load;
    logic         nn_done = 0;
    logic [3:0]   nn_max = 0;
    logic [3:0]   result_digit;
    logic         result_valid;
    logic         result_ready = 0;
    logic         timeout_err;
    logic         busy;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0]   img [32];
    logic [255:0] last_frame = '0;

    image_frame_loader dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .layer_1_input(layer_1_input), .load(load), .nn_done(nn_done), .nn_max(nn_max),
        .result_digit(result_digit), .result_valid(result_valid), .result_ready(result_ready),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Earliest byte lands in the top byte lane, last byte in the bottom one.
    function automatic logic [255:0] model_frame();
        logic [255:0] f = '0;
        for (int i = 0; i < 32; i++) f[255 - 8*i -: 8] = img[i];
        return f;
    endfunction

    task automatic new_img(input bit ramp);
        for (int i = 0; i < 32; i++) img[i] = ramp ? 8'(i) : 8'($urandom);
    endtask

    // Streams img; returns positioned in the cycle after the last byte (LOAD expected).
    task automatic stream_img(input bit toggle);
        int idx = 0;
        int cyc = 0;
        while (idx < 32 && cyc < 200) begin
            n_checks++;
            if (s_ready !== 1'b1 || load !== 1'b0 || layer_1_input !== last_frame) begin
                n_fail++;
                $display("FAIL fill_state: byte %0d s_ready=%b load=%b frame_held=%b, required 1/0/1",
                         idx, s_ready, load, layer_1_input === last_frame);
            end
            s_valid = !toggle || (cyc % 2 == 0);
            s_data  = s_valid ? img[idx] : 8'($urandom);
            tick();
            if (s_valid) idx++;
            cyc++;
        end
        s_valid = 0;
        n_checks++;
        if (idx != 32) begin
            n_fail++;
            $display("FAIL fill_count: accepted %0d bytes, required 32", idx);
        end
        n_checks++;
        if (load !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_pulse: load=%b s_ready=%b busy=%b, required 1/0/1", load, s_ready, busy);
        end
        n_checks++;
        if (layer_1_input !== model_frame()) begin
            n_fail++;
            $display("FAIL frame_value: got %h required %h", layer_1_input, model_frame());
        end
        last_frame = model_frame();
    endtask

    // From the LOAD cycle: waits since_load cycles (dropping a held done at
    // cycle hold) while offering junk bytes, then raises done with digit.
    task automatic complete(input logic [3:0] digit, input int since_load, input int hold);
        for (int c = 0; c < since_load; c++) begin
            if (c == hold) nn_done = 0;
            s_valid = 1;
            s_data  = 8'($urandom);
            n_checks++;
            if (result_valid !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1 ||
                load !== (c == 0) || layer_1_input !== last_frame) begin
                n_fail++;
                $display("FAIL wait_state: cycle %0d rv=%b s_ready=%b busy=%b load=%b frame_held=%b, required 0/0/1/%0d/1",
                         c, result_valid, s_ready, busy, load, layer_1_input === last_frame, c == 0);
            end
            tick();
        end
        s_valid = 0;
        nn_done = 1;
        nn_max  = digit;
        tick();
        nn_max = 4'($urandom);
        n_checks++;
        if (result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_latency_early: result_valid=%b one cycle after done, required 0", result_valid);
        end
        tick();
        n_checks++;
        if (result_valid !== 1'b1 || result_digit !== digit || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL done_result: rv=%b digit=%h err=%b, required 1/%h/0",
                     result_valid, result_digit, timeout_err, digit);
        end
    endtask

    task automatic handshake(input int stall, input logic [3:0] digit, input logic err);
        result_ready = 0;
        for (int c = 0; c < stall; c++) begin
            nn_max  = 4'($urandom);
            nn_done = 1'(c % 2);
            s_valid = 1;
            s_data  = 8'($urandom);
            n_checks++;
            if (result_valid !== 1'b1 || result_digit !== digit || timeout_err !== err || s_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL result_hold: stall %0d rv=%b digit=%h err=%b s_ready=%b, required 1/%h/%b/0",
                         c, result_valid, result_digit, timeout_err, s_ready, digit, err);
            end
            tick();
        end
        s_valid = 0;
        result_ready = 1;
        tick();
        result_ready = 0;
        n_checks++;
        if (result_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL handshake_return: rv=%b s_ready=%b busy=%b, required 0/1/0",
                     result_valid, s_ready, busy);
        end
    endtask

    task automatic run_frame(input bit toggle, input int stall);
        logic [3:0] d = 4'($urandom_range(0, 14));
        new_img(0);
        stream_img(toggle);
        complete(d, $urandom_range(2, 20), 0);
        handshake(stall, d, 0);
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
        n_checks++;
        if (s_ready !== 1'b1 || load !== 1'b0 || result_valid !== 1'b0 || timeout_err !== 1'b0 ||
            busy !== 1'b0 || result_digit !== 4'h0 || layer_1_input !== '0) begin
            n_fail++;
            $display("FAIL reset_values: s_ready=%b load=%b rv=%b err=%b busy=%b digit=%h frame_zero=%b, required 1/0/0/0/0/0/1",
                     s_ready, load, result_valid, timeout_err, busy, result_digit, layer_1_input === '0);
        end
        last_frame = '0;
    endtask

    task automatic test_stream();
        logic [3:0] d = 4'($urandom_range(0, 14));
        new_img(1);
        stream_img(0);
        n_checks++;
        if (layer_1_input[255:248] !== 8'h00 || layer_1_input[7:0] !== 8'h1F) begin
            n_fail++;
            $display("FAIL ramp_lanes: top=%h bottom=%h, required 00/1f",
                     layer_1_input[255:248], layer_1_input[7:0]);
        end
        complete(d, 5, 0);
        handshake(0, d, 0);
    endtask

    task automatic test_holdover();
        nn_done = 1;
        new_img(0);
        stream_img(0);
        complete(4'd4, 40, 10);
        handshake(0, 4'd4, 0);
    endtask

    task automatic test_toggle();
        run_frame(1, 0);
        run_frame(0, 0);
    endtask

    task automatic test_timeout();
        int n = 0;
        nn_done = 0;
        new_img(0);
        stream_img(0);
        while (result_valid !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        n_checks++;
        if (n != 4097) begin
            n_fail++;
            $display("FAIL timeout_latency: result after %0d cycles from load, required 4097", n);
        end
        n_checks++;
        if (result_digit !== 4'hF || timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_result: digit=%h err=%b, required f/1", result_digit, timeout_err);
        end
        handshake(3, 4'hF, 1);
        run_frame(0, 0);
    endtask

    task automatic test_edge_vs_timeout();
        logic [3:0] d = 4'($urandom_range(0, 14));
        nn_done = 0;
        new_img(0);
        stream_img(0);
        for (int i = 0; i < 4095; i++) tick();
        nn_done = 1;
        nn_max  = d;
        tick();
        n_checks++;
        if (result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_tmo_early: result_valid=%b, required 0", result_valid);
        end
        tick();
        n_checks++;
        if (result_valid !== 1'b1 || result_digit !== d || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_beats_timeout: rv=%b digit=%h err=%b, required 1/%h/0",
                     result_valid, result_digit, timeout_err, d);
        end
        handshake(0, d, 0);
    endtask

    task automatic test_stall();
        logic [3:0] d = 4'($urandom_range(0, 14));
        new_img(0);
        stream_img(0);
        complete(d, 7, 0);
        handshake(10, d, 0);
    endtask

    task automatic test_reset_mid();
        new_img(0);
        for (int i = 0; i < 17; i++) begin
            s_valid = 1;
            s_data  = img[i];
            tick();
        end
        s_valid = 0;
        reset = 1;
        tick();
        reset = 0;
        n_checks++;
        if (layer_1_input !== '0 || s_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: frame_zero=%b s_ready=%b busy=%b rv=%b, required 1/1/0/0",
                     layer_1_input === '0, s_ready, busy, result_valid);
        end
        last_frame = '0;
        run_frame(0, 0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_holdover();
        test_toggle();
        test_stall();
        test_timeout();
        test_edge_vs_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
